// File: rtl/lfr_motion_ctrl.sv
// Line-follower motion controller.
// Synchronizes the run/estop/sensor inputs, divides clk_50 into control ticks,
// runs the IDLE/FWD/LEFT/RIGHT/SEARCH/STOP state machine and drives two
// H-bridge channels with ramped duty and dead-time on direction reversal.
// Ports:
//   clk_50, rst_n          clock, async active-low reset
//   enable, estop, sens    asynchronous run request, emergency stop, {L,C,R} sensors
//   l_in1/l_in2/r_in1/r_in2  H-bridge direction bits (10 fwd, 01 rev, 00 coast)
//   l_duty, r_duty         duty commands 0..100
//   state                  FSM state code
//   lost_flag              set when the line search times out
module lfr_motion_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned BASE_DUTY  = 90,
    parameter int unsigned TURN_DUTY  = 40,
    parameter int unsigned RAMP_STEP  = 2,
    parameter int unsigned DEAD_TICKS = 5,
    parameter int unsigned LOST_TICKS = 500
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       estop,
    input  logic [2:0] sens,
    output logic       l_in1,
    output logic       l_in2,
    output logic       r_in1,
    output logic       r_in2,
    output logic [6:0] l_duty,
    output logic [6:0] r_duty,
    output logic [2:0] state,
    output logic       lost_flag
);

    localparam int unsigned CNT_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int unsigned DEAD_W = (DEAD_TICKS < 1) ? 1 : $clog2(DEAD_TICKS + 1);
    localparam int unsigned LOST_W = (LOST_TICKS < 1) ? 1 : $clog2(LOST_TICKS + 1);
    localparam int unsigned BASE_C = (BASE_DUTY > 100) ? 100 : BASE_DUTY;
    localparam int unsigned TURN_C = (TURN_DUTY > 100) ? 100 : TURN_DUTY;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_LEFT   = 3'd2,
        S_RIGHT  = 3'd3,
        S_SEARCH = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    // Encoded as {in1,in2}
    typedef enum logic [1:0] {
        D_COAST = 2'b00,
        D_REV   = 2'b01,
        D_FWD   = 2'b10
    } dir_t;

    typedef struct packed {
        dir_t              dir;
        logic [6:0]        duty;
        logic              dead;      // coasting out a reversal
        dir_t              dead_dir;  // direction to apply once dead-time ends
        logic [DEAD_W-1:0] dead_cnt;
    } motor_t;

    logic [4:0]       sync_a_q, sync_b_q;
    logic             enable_s, estop_s;
    logic [2:0]       sens_s;
    logic [CNT_W-1:0] pre_q;
    logic             tick_c;
    state_t           state_q, state_d;
    logic             lost_q, lost_d;
    logic [LOST_W-1:0] scnt_q, scnt_d;
    logic             last_left_q, last_left_d;
    motor_t           lm_q, lm_d, rm_q, rm_d;
    dir_t             l_tdir, r_tdir;
    logic [6:0]       l_tduty, r_tduty;

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {enable, estop, sens};
            sync_b_q <= sync_a_q;
        end
    end

    assign enable_s = sync_b_q[4];
    assign estop_s  = sync_b_q[3];
    assign sens_s   = sync_b_q[2:0];

    // Free-running control-tick prescaler
    assign tick_c = (pre_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)      pre_q <= '0;
        else if (tick_c) pre_q <= '0;
        else             pre_q <= pre_q + CNT_W'(1);
    end

    function automatic state_t sens_decode(input logic [2:0] s, input state_t cur);
        case (s)
            3'b010, 3'b111: return S_FWD;
            3'b100, 3'b110: return S_LEFT;
            3'b001, 3'b011: return S_RIGHT;
            3'b000:         return S_SEARCH;
            default:        return cur;
        endcase
    endfunction

    // Move duty toward target by at most RAMP_STEP without overshoot
    function automatic logic [6:0] ramp(input logic [6:0] cur, input logic [6:0] tgt);
        int c, t, s;
        c = int'(cur);
        t = int'(tgt);
        s = int'(RAMP_STEP);
        if (t > c)      c = (t - c > s) ? c + s : t;
        else if (c > t) c = (c - t > s) ? c - s : t;
        return 7'(c);
    endfunction

    // One H-bridge channel: ramp, reversal coast, dead-time
    function automatic motor_t motor_step(input motor_t m, input dir_t tdir,
                                          input logic [6:0] tduty, input logic tk);
        motor_t n;
        n = m;
        if (tdir == D_COAST) begin
            n = '0;
        end else if (m.dead) begin
            if (tdir != m.dead_dir) begin
                n.dead_dir = tdir;
                n.dead_cnt = '0;
            end else if (tk) begin
                if (int'(m.dead_cnt) + 1 >= int'(DEAD_TICKS)) begin
                    n.dead     = 1'b0;
                    n.dead_cnt = '0;
                    n.dir      = tdir;
                    n.duty     = ramp(7'd0, tduty);
                end else begin
                    n.dead_cnt = m.dead_cnt + DEAD_W'(1);
                end
            end
        end else if (m.dir != D_COAST && m.dir != tdir) begin
            n.dir      = D_COAST;
            n.duty     = 7'd0;
            n.dead     = 1'b1;
            n.dead_dir = tdir;
            n.dead_cnt = '0;
        end else if (tk) begin
            n.dir  = tdir;
            n.duty = ramp(m.duty, tduty);
        end
        return n;
    endfunction

    // Next-state, search timeout and motor targets
    always_comb begin
        state_d     = state_q;
        lost_d      = lost_q;
        scnt_d      = scnt_q;
        last_left_d = last_left_q;
        l_tdir      = D_COAST;
        r_tdir      = D_COAST;
        l_tduty     = 7'd0;
        r_tduty     = 7'd0;

        if (estop_s) begin
            state_d = S_STOP;
        end else if (!enable_s) begin
            state_d = S_IDLE;
            lost_d  = 1'b0;
        end else if (tick_c) begin
            case (state_q)
                S_IDLE: state_d = S_FWD;
                S_FWD, S_LEFT, S_RIGHT, S_SEARCH: begin
                    state_d = sens_decode(sens_s, state_q);
                    if (state_q == S_SEARCH && state_d == S_SEARCH) begin
                        if (int'(scnt_q) + 1 >= int'(LOST_TICKS)) begin
                            state_d = S_STOP;
                            lost_d  = 1'b1;
                        end else begin
                            scnt_d = scnt_q + LOST_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        if (state_d != S_SEARCH) scnt_d = '0;
        if (state_d == S_LEFT)   last_left_d = 1'b1;
        if (state_d == S_RIGHT)  last_left_d = 1'b0;

        case (state_d)
            S_FWD: begin
                l_tdir = D_FWD; l_tduty = 7'(BASE_C);
                r_tdir = D_FWD; r_tduty = 7'(BASE_C);
            end
            S_LEFT: begin
                l_tdir = D_FWD; l_tduty = 7'(TURN_C);
                r_tdir = D_FWD; r_tduty = 7'(BASE_C);
            end
            S_RIGHT: begin
                l_tdir = D_FWD; l_tduty = 7'(BASE_C);
                r_tdir = D_FWD; r_tduty = 7'(TURN_C);
            end
            S_SEARCH: begin
                // Pivot toward the last turn: inner wheel reverses
                l_tdir  = last_left_q ? D_REV : D_FWD;
                r_tdir  = last_left_q ? D_FWD : D_REV;
                l_tduty = 7'(TURN_C);
                r_tduty = 7'(TURN_C);
            end
            default: ;
        endcase

        lm_d = motor_step(lm_q, l_tdir, l_tduty, tick_c);
        rm_d = motor_step(rm_q, r_tdir, r_tduty, tick_c);
    end

    // State and output registers
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lost_q      <= 1'b0;
            scnt_q      <= '0;
            last_left_q <= 1'b1;
            lm_q        <= '0;
            rm_q        <= '0;
        end else begin
            state_q     <= state_d;
            lost_q      <= lost_d;
            scnt_q      <= scnt_d;
            last_left_q <= last_left_d;
            lm_q        <= lm_d;
            rm_q        <= rm_d;
        end
    end

    assign state          = state_q;
    assign lost_flag      = lost_q;
    assign {l_in1, l_in2} = lm_q.dir;
    assign {r_in1, r_in2} = rm_q.dir;
    assign l_duty         = lm_q.duty;
    assign r_duty         = rm_q.duty;

endmodule

// File: tb/tb_lfr_motion_ctrl.sv
// Directed bench for lfr_motion_ctrl with a 4-cycle control tick.
module tb_lfr_motion_ctrl;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       estop  = 1'b0;
    logic [2:0] sens   = 3'b010;
    logic       l_in1, l_in2, r_in1, r_in2;
    logic [6:0] l_duty, r_duty;
    logic [2:0] state;
    logic       lost_flag;
    logic [3:0] dirs;

    int n_cmp = 0;
    int n_err = 0;

    assign dirs = {l_in1, l_in2, r_in1, r_in2};

    lfr_motion_ctrl #(
        .TICK_DIV  (4),
        .BASE_DUTY (90),
        .TURN_DUTY (40),
        .RAMP_STEP (2),
        .DEAD_TICKS(5),
        .LOST_TICKS(10)
    ) dut (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .enable   (enable),
        .estop    (estop),
        .sens     (sens),
        .l_in1    (l_in1),
        .l_in2    (l_in2),
        .r_in1    (r_in1),
        .r_in2    (r_in2),
        .l_duty   (l_duty),
        .r_duty   (r_duty),
        .state    (state),
        .lost_flag(lost_flag)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next control-tick edge
    task automatic tick();
        repeat (4) @(posedge clk_50);
        #1;
    endtask

    initial begin
        enable = 1'b1;
        sens   = 3'b010;
        repeat (3) @(posedge clk_50);
        #1;
        check("rst_state", state, 0);
        check("rst_dirs", dirs, 0);
        check("rst_lduty", l_duty, 0);
        check("rst_rduty", r_duty, 0);
        check("rst_lost", lost_flag, 0);

        // Forward ramp from 0 to 90
        @(negedge clk_50) rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 1) begin
                check("fwd_state", state, 1);
                check("fwd_dirs", dirs, 4'b1010);
            end
            check("fwd_lduty", l_duty, 2 * k);
            check("fwd_rduty", r_duty, 2 * k);
        end
        tick();
        tick();
        check("fwd_hold_l", l_duty, 90);
        check("fwd_hold_r", r_duty, 90);
        check("fwd_hold_dirs", dirs, 4'b1010);

        // Left turn: inner wheel ramps down to 40
        sens = 3'b100;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 1) check("left_state", state, 2);
            check("left_lduty", l_duty, 90 - 2 * k);
            check("left_rduty", r_duty, 90);
        end
        tick();
        check("left_hold_l", l_duty, 40);
        check("left_dirs", dirs, 4'b1010);

        // Lost line: left reverses after dead-time, then timeout
        sens = 3'b000;
        tick();
        check("srch_state", state, 4);
        check("srch_dirs0", dirs, 4'b0010);
        check("srch_l0", l_duty, 0);
        check("srch_r0", r_duty, 88);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("dead_dirs", dirs, 4'b0010);
            check("dead_lduty", l_duty, 0);
            check("dead_rduty", r_duty, 90 - 2 * (k + 1));
        end
        for (int k = 5; k <= 9; k++) begin
            tick();
            check("rev_dirs", dirs, 4'b0110);
            check("rev_lduty", l_duty, 2 * (k - 4));
            check("rev_state", state, 4);
        end
        tick();
        check("lost_state", state, 5);
        check("lost_flag", lost_flag, 1);
        check("lost_dirs", dirs, 0);
        check("lost_lduty", l_duty, 0);
        check("lost_rduty", r_duty, 0);

        // Disable: IDLE after the synchronizer delay, lost flag cleared
        enable = 1'b0;
        repeat (2) @(posedge clk_50);
        #1;
        check("dis_lat_state", state, 5);
        @(posedge clk_50);
        #1;
        check("dis_state", state, 0);
        check("dis_lost", lost_flag, 0);
        @(posedge clk_50);
        #1;

        // Restart, then emergency stop mid-ramp
        sens   = 3'b010;
        enable = 1'b1;
        tick();
        check("re_state", state, 1);
        check("re_lduty", l_duty, 2);
        tick();
        check("re_lduty2", l_duty, 4);
        estop = 1'b1;
        repeat (3) @(posedge clk_50);
        #1;
        check("estop_state", state, 5);
        check("estop_dirs", dirs, 0);
        check("estop_lduty", l_duty, 0);
        check("estop_rduty", r_duty, 0);
        estop = 1'b0;
        @(posedge clk_50);
        #1;
        tick();
        check("stop_sticky", state, 5);
        enable = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        check("stop_exit", state, 0);
        @(posedge clk_50);
        #1;
        enable = 1'b1;
        tick();
        tick();
        check("pre_rst_state", state, 1);
        check("pre_rst_lduty", l_duty, 4);

        // Asynchronous reset mid-motion
        #2 rst_n = 1'b0;
        #1;
        check("arst_dirs", dirs, 0);
        check("arst_lduty", l_duty, 0);
        check("arst_rduty", r_duty, 0);
        check("arst_state", state, 0);
        @(negedge clk_50) rst_n = 1'b1;
        tick();
        check("rst_ramp_state", state, 1);
        check("rst_ramp_l", l_duty, 2);
        tick();
        check("rst_ramp_l2", l_duty, 4);

        // Right turn, hold on 101, then search pivots right
        sens = 3'b001;
        tick();
        check("right_state", state, 3);
        check("right_lduty", l_duty, 6);
        check("right_rduty", r_duty, 6);
        check("right_dirs", dirs, 4'b1010);
        sens = 3'b101;
        tick();
        check("hold_state", state, 3);
        check("hold_lduty", l_duty, 8);
        sens = 3'b000;
        tick();
        check("srchr_state", state, 4);
        check("srchr_dirs", dirs, 4'b1000);
        check("srchr_rduty", r_duty, 0);
        check("srchr_lduty", l_duty, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
